// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 5..9 data bits LSB first, optional odd/even parity,
// 1 or 2 stop bits. Ready/start handshake lets a source stream back-to-back frames.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_data,
  output logic                 busy,
  output logic                 o_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tick    = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (i_tx_start) begin
          shift_d = i_data;
          par_d   = (PARITY == 1) ? ~^i_data : ^i_data;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    case (state_d)
      START:   data_d = 1'b0;
      DATA:    data_d = shift_d[0];
      PAR:     data_d = par_d;
      default: data_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_ready = ready_q;
  assign busy    = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7O2, 8E1) checked cycle by
// cycle against a frame model built from the bit list of each word.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [7:0] din0;
  logic [6:0] din1;
  logic [7:0] din2;
  logic [2:0] od, rdy, bsy, dn;
  int         tests = 0;
  int         fails = 0;
  bit         exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start[0]), .i_data(din0),
    .o_ready(rdy[0]), .o_data(od[0]), .busy(bsy[0]), .o_done(dn[0]));

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start[1]), .i_data(din1),
    .o_ready(rdy[1]), .o_data(od[1]), .busy(bsy[1]), .o_done(dn[1]));

  uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start[2]), .i_data(din2),
    .o_ready(rdy[2]), .o_data(od[2]), .busy(bsy[2]), .o_done(dn[2]));

  function automatic int cpb_of(input int id);
    return (id == 2) ? 3 : 4;
  endfunction
  function automatic int dbits_of(input int id);
    return (id == 1) ? 7 : 8;
  endfunction
  function automatic int stop_of(input int id);
    return (id == 1) ? 2 : 1;
  endfunction

  task automatic set_in(input int id, input logic s, input logic [8:0] d);
    start[id] = s;
    case (id)
      0:       din0 = d[7:0];
      1:       din1 = d[6:0];
      default: din2 = d[7:0];
    endcase
  endtask

  task automatic chk(input string tag, input int id, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, id, k, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit period.
  task automatic build_expected(input int id, input logic [8:0] d);
    int ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < dbits_of(id); i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (id == 1) exp_q.push_back((ones % 2) == 0);
    if (id == 2) exp_q.push_back((ones % 2) == 1);
    for (int s = 0; s < stop_of(id); s++) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input string tag, input int k);
    for (int id = 0; id < 3; id++) begin
      chk({tag, "_line"},  id, k, od[id],  1'b1);
      chk({tag, "_ready"}, id, k, rdy[id], 1'b1);
      chk({tag, "_busy"},  id, k, bsy[id], 1'b0);
      chk({tag, "_done"},  id, k, dn[id],  1'b0);
    end
  endtask

  // Called #1 after an edge in the cycle that should accept d; poke > 0 pulses
  // i_tx_start with all-ones data in that frame cycle. chain leaves the bench in
  // the o_done cycle so the next call accepts there.
  task automatic frame(input int id, input logic [8:0] d, input int poke, input bit chain);
    int c;
    int f;
    c = cpb_of(id);
    chk("accept_ready", id, 0, rdy[id], 1'b1);
    set_in(id, 1'b1, d);
    build_expected(id, d);
    f = exp_q.size() * c;
    @(posedge clk); #1;
    set_in(id, 1'b0, 9'($urandom));
    for (int k = 1; k <= f; k++) begin
      chk("line",  id, k, od[id],  exp_q[(k - 1) / c]);
      chk("busy",  id, k, bsy[id], 1'b1);
      chk("ready", id, k, rdy[id], 1'b0);
      chk("done",  id, k, dn[id],  1'b0);
      if (k == poke) set_in(id, 1'b1, 9'h1FF);
      else           start[id] = 1'b0;
      @(posedge clk); #1;
    end
    chk("end_done",  id, f + 1, dn[id],  1'b1);
    chk("end_ready", id, f + 1, rdy[id], 1'b1);
    chk("end_busy",  id, f + 1, bsy[id], 1'b0);
    chk("end_line",  id, f + 1, od[id],  1'b1);
    if (!chain) begin
      start[id] = 1'b0;
      @(posedge clk); #1;
      chk("post_done", id, f + 2, dn[id],  1'b0);
      chk("post_busy", id, f + 2, bsy[id], 1'b0);
      chk("post_line", id, f + 2, od[id],  1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int id = 0; id < 3; id++) set_in(id, 1'b1, 9'($urandom));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_idle("rst", k);
    end
    rst = 1'b0;
    start = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_idle("rst_rel", k);
    end

    frame(0, 9'h0A5, 0, 1'b0);
    frame(1, 9'h035, 0, 1'b0);
    frame(2, 9'h007, 0, 1'b0);
    frame(2, 9'h003, 0, 1'b0);

    frame(0, 9'h055, 0, 1'b1);
    frame(0, 9'h0AA, 17, 1'b0);

    set_in(0, 1'b1, 9'h0C3);
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_line",  0, 0, od[0],  1'b1);
    chk("midrst_ready", 0, 0, rdy[0], 1'b1);
    chk("midrst_busy",  0, 0, bsy[0], 1'b0);
    chk("midrst_done",  0, 0, dn[0],  1'b0);
    rst = 1'b0;
    start[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      chk("midrst_quiet_done", 0, k, dn[0], 1'b0);
      chk("midrst_quiet_line", 0, k, od[0], 1'b1);
    end
    frame(0, 9'h03C, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      int id;
      id = int'($urandom_range(0, 2));
      frame(id, 9'($urandom), int'($urandom_range(2, 25)), 1'b1);
      frame(id, 9'($urandom), int'($urandom_range(2, 25)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the iCESugar UART path. It serialises one data word per frame: start bit, 5–9 data bits LSB first, optional odd/even parity, then 1 or 2 stop bits. An internal baud divider sets the bit period. It replaces the fixed 8N1 one-bit-per-clock transmitter. It sits between the byte source (FIFO or command logic) and the TX pin, and uses a ready/start handshake so a source can stream frames back-to-back.

## Interface
- CLKS_PER_BIT, 104: i_clk cycles per bit period (12 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- i_clk  input  1  single clock; all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_tx_start  input  1  request to send; sampled only while o_ready = 1.
- i_data  input  DATA_BITS  word to send; captured on the accepting edge.
- o_ready  output  1  high when idle and able to accept a word.
- o_data  output  1  serial line; idle/mark = 1.
- busy  output  1  high while a frame is in progress. Always equals ~o_ready.
- o_done  output  1  one-cycle pulse when the last stop bit completes.

## Operation
- All outputs are registered.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE
  - o_data = 1, o_ready = 1, busy = 0.
  - When i_tx_start = 1, the edge latches i_data into a shift register, computes the parity bit, clears the baud counter and bit index, and moves to START.
- START: o_data = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA
  - o_data = shift_reg[0] for CLKS_PER_BIT cycles, then shift right.
  - After DATA_BITS bits: go to PAR if PARITY ≠ 0, else STOP.
- PAR
  - o_data = parity bit for CLKS_PER_BIT cycles, then STOP.
  - Odd: the parity bit makes the total count of ones in data+parity odd, i.e. ~^data.
  - Even: parity bit = ^data.
- STOP
  - o_data = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the final cycle's edge: go to IDLE, o_done = 1 for that one cycle, o_ready = 1.
- Baud counter
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT−1, then wraps to 0 and advances the bit.
- i_tx_start while busy is ignored. The word is not queued and o_data is unaffected.
- i_data changes after acceptance have no effect on the current frame.
- Illegal parameter values: elaboration-time $error.

## Timing
- Reset values: o_data = 1, o_ready = 1, busy = 0, o_done = 0, FSM = IDLE, counters = 0.
- Reset mid-frame: the frame is abandoned on the next edge, o_data returns to 1, and no o_done is issued.
- i_rst and i_tx_start high together: reset wins and nothing is accepted.
- Accepting edge t:
  - o_data = 0 and busy = 1 from cycle t+1.
  - The start bit occupies cycles t+1 .. t+CLKS_PER_BIT.
- Frame length: F = (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles of busy = 1.
- o_done and o_ready are high in cycle t+F+1.
- Back-to-back:
  - If i_tx_start = 1 in the o_done cycle, the next start bit begins in cycle t+F+2.
  - The minimum inter-frame gap is exactly one clock of mark.
- Bit boundaries on o_data fall exactly every CLKS_PER_BIT cycles. No drift is permitted across the frame.

## Test plan
- Reset check: hold i_rst for 3 cycles, then release with i_tx_start = 0 → o_data = 1, o_ready = 1, busy = 0, o_done = 0 throughout.
- 8N1, CLKS_PER_BIT = 4, i_data = 8'hA5 → o_data sampled mid-bit = 0,1,0,1,0,0,1,0,1,1. busy is high for exactly 40 cycles and o_done pulses once at cycle 41.
- 7O2, CLKS_PER_BIT = 4, i_data = 7'h35 (four ones) → line = 0, 1,0,1,0,1,1,0, parity 1, 1, 1. F = 44 cycles.
- 8E1 with i_data = 8'h07 → parity bit 1. 8E1 with i_data = 8'h03 → parity bit 0.
- Streaming: hold i_tx_start = 1 with data 8'h55 then 8'hAA.
  - Both frames are sent with exactly one mark cycle between the stop bit and the next start bit.
  - A pulse on i_tx_start mid-frame with 8'hFF is ignored: no extra frame and no line disturbance.
- Reset mid-frame: assert i_rst during DATA bit 3 → o_data = 1 on the next edge, o_ready = 1, no o_done. A new word accepted afterwards is sent correctly.
